// File: rtl/updown_counter_tri.sv
// rtl/updown_counter_tri.sv - parametrised up/down load counter with data/bus capture and tristate drive-back (optional UPDOWN_COUNTER_TRI_SAT_EN saturating mode)
module updown_counter_tri #(
    parameter int               WIDTH     = 8,
    parameter int               STEP      = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic             load_sel,
    input  logic [WIDTH-1:0] data,
    input  logic             oe,
    inout  wire  [WIDTH-1:0] bus,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             bus_drv
);

    localparam logic [WIDTH:0]   STEP_X  = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] bus_cap_q, bus_cap_d;
    logic             wrap_q, wrap_d;
    logic             bus_drv_q, bus_drv_d;
    logic [WIDTH:0]   sum_x;
    logic [WIDTH:0]   dif_x;

    // One extra bit holds the carry (up) or borrow (down) of the step.
    always_comb begin
        sum_x = {1'b0, out_q} + STEP_X;
        dif_x = {1'b0, out_q} - STEP_X;
    end

    // Next-state selection: reset is handled in the flop block, then load > count > hold.
    always_comb begin
        out_d     = out_q;
        wrap_d    = 1'b0;
        data_d    = data;
        bus_cap_d = bus;
        bus_drv_d = oe;
        if (load) begin
            out_d = load_sel ? bus_cap_q : data_q;
        end else if (en) begin
            if (up_down) begin
`ifdef UPDOWN_COUNTER_TRI_SAT_EN
                out_d  = sum_x[WIDTH] ? MAX_VAL : sum_x[WIDTH-1:0];
`else
                out_d  = sum_x[WIDTH-1:0];
                wrap_d = sum_x[WIDTH];
`endif
            end else begin
`ifdef UPDOWN_COUNTER_TRI_SAT_EN
                out_d  = dif_x[WIDTH] ? '0 : dif_x[WIDTH-1:0];
`else
                out_d  = dif_x[WIDTH-1:0];
                wrap_d = dif_x[WIDTH];
`endif
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q     <= RESET_VAL;
            data_q    <= '0;
            bus_cap_q <= '0;
            wrap_q    <= 1'b0;
            bus_drv_q <= 1'b0;
        end else begin
            out_q     <= out_d;
            data_q    <= data_d;
            bus_cap_q <= bus_cap_d;
            wrap_q    <= wrap_d;
            bus_drv_q <= bus_drv_d;
        end
    end

    // The bus is only ever driven from the registered enable, so it releases on the reset edge.
    assign bus     = bus_drv_q ? out_q : {WIDTH{1'bz}};
    assign out     = out_q;
    assign q       = data_q;
    assign wrap    = wrap_q;
    assign bus_drv = bus_drv_q;
    assign tc      = up_down ? (out_q == MAX_VAL) : (out_q == '0);

endmodule

// File: doc/updown_counter_tri.md
Name: updown_counter_tri

Overview:
- Parametrised up/down counter with load, the successor to the fixed 8-bit up/load counter.
- Load value comes from an internal registered data-capture stage or from a bidirectional tristate bus.
- The count can be driven back onto that bus under a registered output enable.
- Sits between a data source and a shared tristate bus. Verilator tristate handling of public inout ports must compile cleanly.

Parameters:
- WIDTH, 8, counter/data/bus width in bits (≥2).
- STEP, 1, increment/decrement magnitude (1 ≤ STEP < 2^WIDTH).
- RESET_VAL, 0, counter value after reset (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  count enable.
- up_down  input  1  1 = count up, 0 = count down.
- load  input  1  load request (priority over counting).
- load_sel  input  1  load source: 0 = captured data, 1 = captured bus.
- data  input  WIDTH  load data, public signal (verilator public).
- oe  input  1  request to drive bus.
- bus  inout  WIDTH  shared tristate bus.
- out  output  WIDTH  counter value.
- q  output  WIDTH  captured data register.
- tc  output  1  terminal count: out at max (up) or 0 (down).
- wrap  output  1  one-cycle pulse when the count wrapped.
- bus_drv  output  1  registered enable currently driving bus.

Behaviour:
- One clock; reset synchronous and active-high. All state updates on the rising clk edge.
- Reset values: out = RESET_VAL, q = 0, bus_q = 0, wrap = 0, bus_drv = 0. While reset is high, bus = Z.
- Capture stage: q <= data every cycle; bus_q <= bus (resolved value) every cycle.
- Load latency from data to out is 2 cycles: data at edge N appears in q after N; load at edge N+1 puts it in out.
- Priority: reset > load > en > hold.
  - load = 1: out <= (load_sel ? bus_q : q); wrap <= 0. en and up_down are ignored.
  - en = 1, up_down = 1: out <= (out + STEP) mod 2^WIDTH; wrap <= 1 if out + STEP ≥ 2^WIDTH.
  - en = 1, up_down = 0: out <= (out − STEP) mod 2^WIDTH; wrap <= 1 if out < STEP.
  - Otherwise: out holds; wrap <= 0.
- Arithmetic: compute in WIDTH+1 bits; the carry/borrow bit feeds wrap; the low WIDTH bits feed out.
- tc is combinational from current out and up_down: up_down ? (out == 2^WIDTH−1) : (out == 0). It is independent of en.
- Tristate:
  - bus_drv <= oe (one-cycle registered).
  - bus = bus_drv ? out : all-Z.
  - No internal assignment drives bus from any other source.
- Load from bus while bus_drv = 1: loads own previous value. This is legal, not an error.
- Simultaneous load + en: load wins, no count that cycle.
- Reset mid-operation: the next edge returns all registers to reset values regardless of load/en/oe. The bus releases on that same edge.
- Undriven bus (all Z, no external driver): bus_q captures X in simulation and 0 in Verilator. No X check is required.

Optional Feature:
- Macro: UPDOWN_COUNTER_TRI_SAT_EN.
- Defined: counting saturates at 2^WIDTH−1 (up) and 0 (down) instead of wrapping.
  - wrap stays 0 always.
  - A count request at the limit leaves out unchanged.
  - Near the limit (out + STEP overflow, or out < STEP when down), out clamps to the limit.
- Undefined: modular wrap as described, and wrap pulses as described.

Test Plan:
- Reset, then en = 1, up_down = 1, STEP = 1 for 5 cycles → out = 1,2,3,4,5 on successive edges; wrap = 0; bus = Z.
- Hold data = 0xA5; assert load = 1, load_sel = 0 one cycle later → out = 0xA5 exactly 2 cycles after data was applied.
- Load 0xFF, then en = 1, up_down = 1 → out = 0x00, wrap = 1 for exactly one cycle, tc = 1 before the wrap. With UPDOWN_COUNTER_TRI_SAT_EN: out stays 0xFF and wrap = 0.
- oe = 1 with out = 0x3C → bus = 0x3C starting one cycle after oe rises. oe = 0 → bus = Z one cycle later. External driver 0x5A then load_sel = 1, load = 1 → out = 0x5A two cycles after the driver applies.
- load = 1 and en = 1 in the same cycle → loaded value only, no increment. reset asserted during counting with oe = 1 → next edge out = RESET_VAL, bus = Z, bus_drv = 0.
- WIDTH = 12, STEP = 3, down from 0x002 → out = 0xFFF, wrap = 1. Verilator lint/compile passes with no tristate errors.
